// File: rtl/sync_ram_clr.sv
// Single-port synchronous RAM with registered read, valid strobe and a self-clearing sweep.
// Define SYNC_RAM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module sync_ram_clr #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] Din,
  input  logic              inj_perr,
  output logic [DATA_W-1:0] Dout,
  output logic              valid,
  output logic              busy,
  output logic              perr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef SYNC_RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic {IDLE, CLEAR} state_e;

  logic [MEM_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              perr_q, perr_d;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [MEM_W-1:0]  mem_wdata_c;
  logic [MEM_W-1:0]  wr_word_c;
  logic [MEM_W-1:0]  rd_word_c;
  logic              perr_rd_c;
  logic              perr_wt_c;

  assign rd_word_c = mem[addr];

`ifdef SYNC_RAM_PARITY_EN
  // Stored parity bit makes the whole word even unless a fault was injected.
  assign wr_word_c = {(^Din) ^ inj_perr, Din};
  assign perr_rd_c = ^rd_word_c;
  assign perr_wt_c = inj_perr;
`else
  logic unused_inj;
  assign unused_inj = inj_perr;
  assign wr_word_c  = Din;
  assign perr_rd_c  = 1'b0;
  assign perr_wt_c  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    perr_d      = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = addr;
    mem_wdata_c = wr_word_c;
    case (state_q)
      CLEAR: begin
        mem_we_c    = rst;
        mem_addr_c  = cnt_q[ADDR_W-1:0];
        mem_wdata_c = '0;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          mem_we_c = wr & rst;
          if (rd) begin
            valid_d = 1'b1;
            if (wr) begin
              dout_d = Din;
              perr_d = perr_wt_c;
            end else begin
              dout_d = rd_word_c[DATA_W-1:0];
              perr_d = perr_rd_c;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= (INIT_CLEAR != 0);
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
    end
  end

  // Array has no reset; writes are suppressed while rst is held low.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
  end

  assign Dout  = dout_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign perr  = perr_q;

endmodule

// File: tb/tb_sync_ram_clr.sv
// Randomized self-checking bench for sync_ram_clr against an array-based reference model.
module tb_sync_ram_clr;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
`ifdef SYNC_RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rd = 1'b0, wr = 1'b0, clr = 1'b0, inj_perr = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] Din = '0;
  logic [DATA_W-1:0] Dout;
  logic              valid, busy, perr;

  sync_ram_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_CLEAR(1)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .clr(clr), .addr(addr),
    .Din(Din), .inj_perr(inj_perr), .Dout(Dout), .valid(valid),
    .busy(busy), .perr(perr)
  );

  always #5 clk = ~clk;

  // Reference model: word contents, injected-fault flag per word, sweep cycles remaining.
  int unsigned       m_data [DEPTH];
  bit                m_inj  [DEPTH];
  int unsigned       sweep_left;
  logic [DATA_W-1:0] exp_dout;
  logic              exp_valid, exp_perr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = 0;
      m_inj[i]  = 1'b0;
    end
  endfunction

  // One clock: drive inputs, advance the model, then compare every output.
  task automatic cycle(input logic r, input logic w, input logic c,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic inj);
    rd = r; wr = w; clr = c; addr = a; Din = d; inj_perr = inj;
    @(posedge clk);
    exp_valid = 1'b0;
    exp_perr  = 1'b0;
    if (sweep_left > 0) begin
      sweep_left--;
    end else if (c) begin
      model_clear();
      sweep_left = DEPTH;
    end else begin
      if (w) begin
        m_data[a] = d;
        m_inj[a]  = inj;
      end
      if (r) begin
        exp_valid = 1'b1;
        exp_dout  = DATA_W'(m_data[a]);
        exp_perr  = PAR & m_inj[a];
      end
    end
    #1;
    chk("dout",  32'(Dout),  32'(exp_dout));
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("busy",  32'(busy),  32'(sweep_left > 0));
    chk("perr",  32'(perr),  32'(exp_perr));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Assert reset between edges with a write pending; the write must not land.
  task automatic do_reset();
    rst = 1'b0; wr = 1'b1; rd = 1'b1; Din = 8'h5A;
    #1;
    chk("rst_dout",  32'(Dout),  32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_perr",  32'(perr),  32'h0);
    chk("rst_busy",  32'(busy),  32'h1);
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    rst = 1'b1;
    model_clear();
    sweep_left = DEPTH;
    exp_dout   = '0;
  endtask

  // Count cycles with busy high, bounded; pre counts cycles already spent.
  task automatic wait_sweep(input string tag, input int pre);
    int n = pre;
    while (busy === 1'b1 && n < DEPTH + 8) begin
      idle();
      n++;
    end
    chk(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sweep_left = 0;
    exp_dout = '0; exp_valid = 1'b0; exp_perr = 1'b0;
    #12;
    do_reset();
    wait_sweep("t1_busy_len", 0);
    cycle(1'b1, 1'b0, 1'b0, 8'h03, '0, 1'b0);
    chk("t1_rd3", 32'(Dout), 32'h0);

    // Back-to-back reads after three writes.
    cycle(1'b0, 1'b1, 1'b0, 8'h4E, 8'd8,  1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h62, 8'd15, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'hF0, 8'd27, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h4E, '0, 1'b0);
    chk("t2_rd0", 32'(Dout), 32'd8);
    cycle(1'b1, 1'b0, 1'b0, 8'h62, '0, 1'b0);
    chk("t2_rd1", 32'(Dout), 32'd15);
    cycle(1'b1, 1'b0, 1'b0, 8'hF0, '0, 1'b0);
    chk("t2_rd2", 32'(Dout), 32'd27);
    idle();

    // Write-through then plain read-back.
    cycle(1'b1, 1'b1, 1'b0, 8'h10, 8'hA5, 1'b0);
    chk("t3_wt", 32'(Dout), 32'hA5);
    idle();
    cycle(1'b1, 1'b0, 1'b0, 8'h10, '0, 1'b0);
    chk("t3_rd", 32'(Dout), 32'hA5);

    // Reset in the middle of a write sequence.
    cycle(1'b0, 1'b1, 1'b0, 8'hAA, 8'h3C, 1'b0);
    do_reset();
    wait_sweep("t4_busy_len", 0);
    cycle(1'b1, 1'b0, 1'b0, 8'hAA, '0, 1'b0);
    chk("t4_rd", 32'(Dout), 32'h0);

    // On-demand clear; a write issued while busy is dropped.
    cycle(1'b0, 1'b1, 1'b0, 8'h05, 8'h11, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h00, '0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h05, 8'h77, 1'b0);
    wait_sweep("t5_busy_len", 1);
    cycle(1'b1, 1'b0, 1'b0, 8'h05, '0, 1'b0);
    chk("t5_rd", 32'(Dout), 32'h0);

    // Parity fault injection.
    cycle(1'b0, 1'b1, 1'b0, 8'h01, 8'h81, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 8'h02, 8'h81, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h01, '0, 1'b0);
    chk("t6_perr_inj", 32'(perr), 32'(PAR));
    cycle(1'b1, 1'b0, 1'b0, 8'h02, '0, 1'b0);
    chk("t6_perr_ok", 32'(perr), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 8'h03, 8'h42, 1'b1);
    chk("t6_perr_wt", 32'(perr), 32'(PAR));

    // Reset partway through a clear sweep.
    cycle(1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 20; i++) idle();
    do_reset();
    wait_sweep("t7_busy_len", 0);

    // Randomized traffic on a narrow address window to force hits.
    for (int i = 0; i < 2500; i++) begin
      logic [ADDR_W-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 299) == 0), a,
            DATA_W'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_ram_clr.md
Name: sync_ram_clr

Overview:
- Parametrised single-port synchronous RAM.
- Next generation of the team's 8x256 memory block: configurable width and depth, registered read with valid strobe, self-clearing sweep after reset and on demand, and optional parity protection.
- Used as a scratch/lookup store inside datapath blocks; one access per cycle.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 8: address width; depth DEPTH = 2**ADDR_W words.
- INIT_CLEAR, 1: 1 = run the clear sweep after every reset release; 0 = array contents undefined after reset, block idle immediately.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd  input  1  read request, sampled on clk.
- wr  input  1  write request, sampled on clk.
- clr  input  1  start a clear sweep (single-cycle pulse, honoured only in IDLE).
- addr  input  ADDR_W  word address.
- Din  input  DATA_W  write data.
- inj_perr  input  1  parity fault injection on write; ignored unless PARITY_EN is defined.
- Dout  output  DATA_W  registered read data.
- valid  output  1  one-cycle strobe: Dout updated this cycle.
- busy  output  1  high while a clear sweep runs.
- perr  output  1  parity error on the current read; qualified by valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - Dout=0, valid=0, perr=0, sweep counter=0.
  - INIT_CLEAR=1: state=CLEAR, busy=1. INIT_CLEAR=0: state=IDLE, busy=0.
  - The memory array is not reset asynchronously.
- States: IDLE, CLEAR.
- CLEAR:
  - Each cycle writes 0 to mem[cnt] (parity bit 0 under PARITY_EN), then cnt++.
  - After the write to DEPTH-1, go to IDLE and set cnt=0.
  - busy is high for exactly DEPTH cycles after reset release or after the clr edge.
  - rd, wr and clr are ignored; valid stays 0 and Dout holds.
- IDLE:
  - clr=1 enters CLEAR on the next edge and has priority over rd/wr in the same cycle. That cycle's access is dropped.
  - wr=1, rd=0: mem[addr] <= Din. valid=0.
  - rd=1, wr=0: Dout <= mem[addr] on the same edge. valid=1 for that one cycle, so latency is 1 clock.
  - rd=1, wr=1 on the same address: write-through. mem[addr] <= Din, Dout <= Din, valid=1.
  - Neither request: valid=0, Dout holds its last value.
- Back-to-back reads on consecutive cycles: valid stays high and Dout updates every cycle.
- Addresses use the full ADDR_W range, with no out-of-range case. The sweep counter is ADDR_W+1 bits wide to detect the end of the sweep.
- Reset asserted mid-sweep or mid-access: outputs clear immediately. After release the sweep restarts from address 0 (INIT_CLEAR=1). A write on the edge where rst is low is not performed.

Optional Feature:
- Macro: SYNC_RAM_PARITY_EN.
- Defined:
  - Array is DATA_W+1 bits wide; the extra bit is even parity of Din, XORed with inj_perr, on write.
  - On a read, perr=1 together with valid when the stored parity does not match the recomputed parity. Otherwise perr=0.
  - A write-through read computes perr from Din and inj_perr.
- Not defined: array is DATA_W bits, perr is tied 0, inj_perr is unused.

Test Plan:
1. DATA_W=8, ADDR_W=4, INIT_CLEAR=1; release rst -> busy=1 for exactly 16 cycles, then 0. rd at addr 3 -> next cycle Dout=0x00, valid=1.
2. Defaults; after sweep write 8 @0x4E, 15 @0x62, 27 @0xF0; read 0x4E, 0x62, 0xF0 back-to-back -> Dout 8, 15, 27 on consecutive cycles, valid high for 3 cycles.
3. rd=1, wr=1, addr=0x10, Din=0xA5 -> next cycle Dout=0xA5, valid=1. A later plain read of 0x10 returns 0xA5.
4. Write 0x3C @0xAA, pull rst low mid-write-sequence -> Dout=0, valid=0 immediately. After release and sweep, read 0xAA -> 0x00.
5. In IDLE pulse clr, then issue wr 0x77 @0x05 during busy -> busy lasts 256 cycles. Afterwards read 0x05 -> 0x00 (write dropped).
6. SYNC_RAM_PARITY_EN defined: write 0x81 @0x01 with inj_perr=1 -> read gives perr=1, valid=1. Write 0x81 @0x02 with inj_perr=0 -> read gives perr=0. Macro undefined: perr=0 in both cases.
